// File: rtl/cnt_cap_pkg.sv
// Shared types and helpers for the ripple-counter capture block: default widths,
// snapshot FSM state encoding and the modular decrement used for step checking.
package cnt_cap_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } snap_state_e;

  // Expected successor of a down-counter value, wrapping 0 -> all-ones.
  function automatic logic [CNT_W_DEF-1:0] dec_mod(input logic [CNT_W_DEF-1:0] x);
    return x - 1'b1;
  endfunction

endpackage

// File: rtl/cnt_sync_filter.sv
// Two-flop resynchroniser followed by a stability filter: a value is offered for
// acceptance only after it has been seen on STABLE_CYCLES+1 consecutive samples.
module cnt_sync_filter
  import cnt_cap_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] stable_val,
  output logic             accept_ok
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0]  sync1_q, sync1_d;
  logic [CNT_W-1:0]  sync2_q, sync2_d;
  logic [CNT_W-1:0]  cand_q,  cand_d;
  logic [STAB_W-1:0] stab_q,  stab_d;

  always_comb begin
    sync1_d   = cnt_in;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    stab_d    = stab_q;
    accept_ok = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      stab_d = '0;
    end else if (stab_q == STAB_MAX) begin
      // Saturated: keep offering the candidate; the consumer decides if it is new.
      accept_ok = 1'b1;
    end else begin
      stab_d = stab_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      cand_q  <= '1;
      stab_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
    end
  end

  assign stable_val = cand_q;

endmodule

// File: rtl/ripple_count_capture.sv
// Captures a free-running ripple down-counter into the clk domain, counts underflow
// wraps, flags out-of-sequence steps and offers a req/ack snapshot of the state.
module ripple_count_capture
  import cnt_cap_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = WRAP_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CNT_W-1:0]        cnt_in,
  input  logic                    clr,
  input  logic                    snap_req,
  input  logic                    snap_ack,
  output logic [CNT_W-1:0]        cnt_out,
  output logic                    cnt_strobe,
  output logic                    underflow,
  output logic                    seq_error,
  output logic [WRAP_W-1:0]       wrap_count,
  output logic                    wrap_sat,
  output logic                    snap_valid,
  output logic [WRAP_W+CNT_W-1:0] snap_data
);

  logic [CNT_W-1:0] cand;
  logic             accept_ok;
  logic             accept;
  logic [CNT_W-1:0] pred;

  logic [CNT_W-1:0]  cnt_out_q,    cnt_out_d;
  logic              strobe_q,     strobe_d;
  logic              underflow_q,  underflow_d;
  logic              seq_error_q,  seq_error_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic              wrap_sat_q,   wrap_sat_d;

  snap_state_e               state_q;
  logic                      snap_valid_q;
  logic [WRAP_W+CNT_W-1:0]   snap_data_q;

  cnt_sync_filter #(
    .CNT_W         (CNT_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .stable_val (cand),
    .accept_ok  (accept_ok)
  );

  generate
    if (CNT_W == CNT_W_DEF) begin : g_pred_pkg
      assign pred = dec_mod(cnt_out_q);
    end else begin : g_pred_gen
      assign pred = cnt_out_q - 1'b1;
    end
  endgenerate

  // A stable value that merely repeats the current output is not a new step.
  assign accept = accept_ok && (cand != cnt_out_q);

  always_comb begin
    cnt_out_d    = cnt_out_q;
    strobe_d     = 1'b0;
    underflow_d  = 1'b0;
    seq_error_d  = 1'b0;
    wrap_count_d = wrap_count_q;
    wrap_sat_d   = wrap_sat_q;
    if (accept) begin
      cnt_out_d   = cand;
      strobe_d    = 1'b1;
      underflow_d = (cnt_out_q == '0) && (cand == '1);
      seq_error_d = (cand != pred);
    end
    if (clr) begin
      wrap_count_d = '0;
      wrap_sat_d   = 1'b0;
    end else if (underflow_d) begin
      if (wrap_count_q != '1) begin
        wrap_count_d = wrap_count_q + 1'b1;
      end else begin
        wrap_sat_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_out_q    <= '1;
      strobe_q     <= 1'b0;
      underflow_q  <= 1'b0;
      seq_error_q  <= 1'b0;
      wrap_count_q <= '0;
      wrap_sat_q   <= 1'b0;
    end else begin
      cnt_out_q    <= cnt_out_d;
      strobe_q     <= strobe_d;
      underflow_q  <= underflow_d;
      seq_error_q  <= seq_error_d;
      wrap_count_q <= wrap_count_d;
      wrap_sat_q   <= wrap_sat_d;
    end
  end

  // Snapshot captures the register values as they stood before this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (snap_req) begin
            snap_data_q  <= {wrap_count_q, cnt_out_q};
            snap_valid_q <= 1'b1;
            state_q      <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (snap_ack) begin
            snap_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          snap_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign cnt_out    = cnt_out_q;
  assign cnt_strobe = strobe_q;
  assign underflow  = underflow_q;
  assign seq_error  = seq_error_q;
  assign wrap_count = wrap_count_q;
  assign wrap_sat   = wrap_sat_q;
  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench for ripple_count_capture: directed scenarios plus random ripple
// traffic, checked against a run-length reference model of the capture behaviour.
module tb_ripple_count_capture;

  localparam int CNT_W  = 4;
  localparam int WRAP_W = 8;
  localparam int STABLE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr = 1'b0;
  logic snap_req = 1'b0;
  logic snap_ack = 1'b0;
  logic [CNT_W-1:0] cnt_in = 4'hF;

  logic [CNT_W-1:0]        cnt_out;
  logic                    cnt_strobe, underflow, seq_error, wrap_sat, snap_valid;
  logic [WRAP_W-1:0]       wrap_count;
  logic [WRAP_W+CNT_W-1:0] snap_data;

  always #5 clk = ~clk;

  ripple_count_capture #(
    .CNT_W(CNT_W), .STABLE_CYCLES(STABLE), .WRAP_W(WRAP_W)
  ) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .clr(clr),
    .snap_req(snap_req), .snap_ack(snap_ack),
    .cnt_out(cnt_out), .cnt_strobe(cnt_strobe), .underflow(underflow),
    .seq_error(seq_error), .wrap_count(wrap_count), .wrap_sat(wrap_sat),
    .snap_valid(snap_valid), .snap_data(snap_data)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] cnt;
    logic       uf;
    logic       se;
    logic [7:0] wrap;
    logic       sat;
  } acc_t;

  acc_t        acc_q[$];
  logic [11:0] snap_q[$];

  // Reference model state (committed at each rising edge)
  logic [3:0] m_cnt = 4'hF;
  logic [7:0] m_wrap = 8'h00;
  logic       m_sat = 1'b0;
  logic       m_hold = 1'b0;
  logic       m_strobe = 1'b0;
  logic [3:0] in_m1 = 4'hF, in_m2 = 4'hF, last_obs = 4'hF;
  int         run = 1;
  bit         started = 0;
  bit         auto_clr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the effect of the coming edge from the current inputs, then take the edge.
  task automatic tick();
    logic [3:0] obs, n_cnt;
    logic [7:0] n_wrap;
    logic       n_sat, n_hold, n_strobe, uf, se, acc;
    acc_t       a;
    if (reset) begin
      n_cnt = 4'hF; n_wrap = 8'h00; n_sat = 1'b0; n_hold = 1'b0; n_strobe = 1'b0;
      in_m1 = 4'hF; in_m2 = 4'hF; last_obs = 4'hF; run = 1;
    end else begin
      // The filter sees the input as it was two edges ago.
      obs = in_m2; in_m2 = in_m1; in_m1 = cnt_in;
      if (obs == last_obs) begin
        if (run < 1000) run++;
      end else begin
        last_obs = obs; run = 1;
      end
      acc = (run >= STABLE + 1) && (obs != m_cnt);
      n_cnt = m_cnt; uf = 1'b0; se = 1'b0;
      if (acc) begin
        n_cnt = obs;
        uf = (m_cnt == 4'h0) && (obs == 4'hF);
        se = (obs != 4'(m_cnt - 1));
      end
      if (auto_clr && uf) clr = 1'b1;
      n_wrap = m_wrap; n_sat = m_sat;
      if (clr) begin
        n_wrap = 8'h00; n_sat = 1'b0;
      end else if (uf) begin
        if (m_wrap == 8'hFF) n_sat = 1'b1;
        else n_wrap = m_wrap + 8'd1;
      end
      if (acc) begin
        a.cnt = n_cnt; a.uf = uf; a.se = se; a.wrap = n_wrap; a.sat = n_sat;
        acc_q.push_back(a);
      end
      n_hold = m_hold;
      if (!m_hold && snap_req) begin
        snap_q.push_back({m_wrap, m_cnt});
        n_hold = 1'b1;
      end else if (m_hold && snap_ack) begin
        n_hold = 1'b0;
      end
      n_strobe = acc;
    end
    @(posedge clk);
    m_cnt = n_cnt; m_wrap = n_wrap; m_sat = n_sat; m_hold = n_hold; m_strobe = n_strobe;
    started = 1;
    #1;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    cnt_in = v;
    repeat (n) tick();
  endtask

  // Monitor: pops expected transactions whenever the DUT presents one.
  logic        sv_prev = 1'b0;
  logic [11:0] exp_snap = '0;
  acc_t        e;
  always @(negedge clk) begin
    if (started) begin
      chk("cnt_out", 32'(cnt_out), 32'(m_cnt));
      chk("cnt_strobe", 32'(cnt_strobe), 32'(m_strobe));
      chk("wrap_count", 32'(wrap_count), 32'(m_wrap));
      chk("wrap_sat", 32'(wrap_sat), 32'(m_sat));
      chk("snap_valid", 32'(snap_valid), 32'(m_hold));
      if (cnt_strobe) begin
        if (acc_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL strobe_unexpected: got cnt=%0h expected no strobe", cnt_out);
        end else begin
          e = acc_q.pop_front();
          $display("strobe cnt=%0h uf=%0b se=%0b wrap=%0h sat=%0b", cnt_out, underflow,
                   seq_error, wrap_count, wrap_sat);
          chk("acc_cnt", 32'(cnt_out), 32'(e.cnt));
          chk("acc_underflow", 32'(underflow), 32'(e.uf));
          chk("acc_seq_error", 32'(seq_error), 32'(e.se));
        end
      end else begin
        chk("idle_pulses", 32'({underflow, seq_error}), 32'd0);
      end
      if (snap_valid && !sv_prev) begin
        if (snap_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL snap_unexpected: got data=%0h expected no capture", snap_data);
        end else begin
          exp_snap = snap_q.pop_front();
          $display("snapshot data=%03h", snap_data);
          chk("snap_data", 32'(snap_data), 32'(exp_snap));
        end
      end else if (snap_valid) begin
        chk("snap_frozen", 32'(snap_data), 32'(exp_snap));
      end
      sv_prev = snap_valid;
    end
  end

  int lat;

  initial begin
    // 1. reset with the counter idle at all-ones
    reset = 1'b1; cnt_in = 4'hF;
    repeat (3) tick();
    reset = 1'b0;
    hold(4'hF, 6);
    chk("rst_cnt_out", 32'(cnt_out), 32'hF);
    chk("rst_snap_data", 32'(snap_data), 32'h0);
    chk("rst_wrap", 32'(wrap_count), 32'h0);

    // 2. single step F -> E and its latency
    cnt_in = 4'hE; lat = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cnt_strobe && lat < 0) lat = i;
    end
    chk("t2_latency", 32'(lat), 32'(2 + STABLE));
    chk("t2_cnt", 32'(cnt_out), 32'hE);

    // 3. count down through zero, then saturate the wrap counter
    for (int v = 13; v >= 0; v--) hold(4'(v), 4);
    hold(4'hF, 5);
    chk("t3_first_wrap", 32'(wrap_count), 32'h1);
    for (int i = 0; i < 255; i++) begin
      hold(4'h0, 3);
      hold(4'hF, 3);
    end
    hold(4'hF, 4);
    chk("t3_wrap_sat_cnt", 32'(wrap_count), 32'hFF);
    chk("t3_wrap_sat", 32'(wrap_sat), 32'h1);

    // 4. one-cycle ripple glitch, then an out-of-sequence step
    hold(4'h8, 6);
    hold(4'hF, 1);
    hold(4'h7, 6);
    chk("t4_after_glitch", 32'(cnt_out), 32'h7);
    hold(4'h5, 6);
    hold(4'h2, 6);

    // 5. snapshot with wrap_count=3, cnt_out=9
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hold(4'h0, 5);
      hold(4'hF, 5);
    end
    hold(4'h9, 6);
    snap_req = 1'b1; tick();
    chk("t5_snap", 32'(snap_data), 32'h039);
    hold(4'h8, 6);
    snap_ack = 1'b1; tick(); snap_ack = 1'b0; snap_req = 1'b0;
    tick();
    chk("t5_valid_drop", 32'(snap_valid), 32'h0);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    chk("t5_snap2", 32'(snap_data), 32'h038);
    snap_ack = 1'b1; tick(); snap_ack = 1'b0;

    // 6. clr coinciding with underflow, then reset during a held snapshot
    hold(4'h0, 6);
    auto_clr = 1; cnt_in = 4'hF;
    repeat (8) begin
      tick(); clr = 1'b0;
    end
    auto_clr = 0;
    chk("t6_clr_wins", 32'(wrap_count), 32'h0);
    hold(4'h3, 6);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    hold(4'h2, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_rst_valid", 32'(snap_valid), 32'h0);
    chk("t6_rst_cnt", 32'(cnt_out), 32'hF);

    // Random ripple traffic with glitches, clears, snapshots and occasional reset
    for (int i = 0; i < 400; i++) begin
      snap_req = 1'($urandom_range(0, 1));
      snap_ack = 1'($urandom_range(0, 1));
      clr      = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 60) == 0);
      hold(4'($urandom_range(0, 15)), $urandom_range(1, 6));
    end
    reset = 1'b0; clr = 1'b0; snap_req = 1'b0; snap_ack = 1'b1;
    hold(cnt_in, 8);
    snap_ack = 1'b0;
    chk("acc_queue_drained", 32'(acc_q.size()), 32'd0);
    chk("snap_queue_drained", 32'(snap_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
